// File: rtl/mult_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mult_scheduler_if
// Description : ID-stage request, forwarding context and scheduler results
//               exchanged with the multiplier scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef REG_ADDR
`define REG_ADDR 5
`endif

interface mult_scheduler_if #(
    parameter int REG_ADDR = `REG_ADDR
);
    logic                id_valid;
    logic                id_is_mult;
    logic                id_regwrite;
    logic [REG_ADDR-1:0] id_dst_reg;
    logic [REG_ADDR-1:0] id_src1;
    logic [REG_ADDR-1:0] id_src2;
    logic [REG_ADDR-1:0] id_ex_dst_reg;
    logic [REG_ADDR-1:0] ex_mem_dst_reg;
    logic                id_ex_regwrite;
    logic                ex_mem_regwrite;
    logic                flush;
    logic                stall;
    logic                mult_issue;
    logic                m_wb_valid;
    logic [REG_ADDR-1:0] m_wb_dst;
    logic [2:0]          mult_inflight;
    logic [15:0]         stall_cnt;

    modport master (
        output id_valid, id_is_mult, id_regwrite, id_dst_reg, id_src1, id_src2,
               id_ex_dst_reg, ex_mem_dst_reg, id_ex_regwrite, ex_mem_regwrite, flush,
        input  stall, mult_issue, m_wb_valid, m_wb_dst, mult_inflight, stall_cnt
    );

    modport slave (
        input  id_valid, id_is_mult, id_regwrite, id_dst_reg, id_src1, id_src2,
               id_ex_dst_reg, ex_mem_dst_reg, id_ex_regwrite, ex_mem_regwrite, flush,
        output stall, mult_issue, m_wb_valid, m_wb_dst, mult_inflight, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/mult_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mult_scheduler
// Description : Hazard detection and tracking for a fixed-latency multiplier
//               sharing the register-file write port with the ALU pipe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef REG_ADDR
`define REG_ADDR 5
`endif

module mult_scheduler #(
    parameter int MULT_LAT = 5,
    parameter int REG_ADDR = `REG_ADDR
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mult_scheduler_if.slave  bus
);
    localparam int c_nreg = 1 << REG_ADDR;

    logic [MULT_LAT-1:0]               r_pipe_valid;
    logic [MULT_LAT-1:0]               r_pipe_wr;
    logic [MULT_LAT-1:0][REG_ADDR-1:0] r_pipe_dst;
    logic [c_nreg-1:0]                 r_busy;
    logic                              r_wb_valid;
    logic [REG_ADDR-1:0]               r_wb_dst;
    logic [15:0]                       r_stall_cnt;

    logic [c_nreg-1:0] w_busy_nxt;
    logic              w_raw;
    logic              w_waw;
    logic              w_fwd;
    logic              w_struct;
    logic              w_stall;
    logic              w_issue;
    logic              w_retire;
    logic [2:0]        w_inflight;

    // Multiplies read operands in ID, so they cannot take ALU results still in EX/MEM.
    always_comb begin
        w_raw = ((bus.id_src1 != '0) && r_busy[bus.id_src1]) ||
                ((bus.id_src2 != '0) && r_busy[bus.id_src2]);
        w_waw = bus.id_regwrite && (bus.id_dst_reg != '0) && r_busy[bus.id_dst_reg];
        w_fwd = bus.id_is_mult && (
                ((bus.id_src1 != '0) &&
                 ((bus.id_ex_regwrite  && (bus.id_src1 == bus.id_ex_dst_reg)) ||
                  (bus.ex_mem_regwrite && (bus.id_src1 == bus.ex_mem_dst_reg)))) ||
                ((bus.id_src2 != '0) &&
                 ((bus.id_ex_regwrite  && (bus.id_src2 == bus.id_ex_dst_reg)) ||
                  (bus.ex_mem_regwrite && (bus.id_src2 == bus.ex_mem_dst_reg)))));
        w_struct = bus.id_regwrite && !bus.id_is_mult && r_pipe_valid[1] && r_pipe_wr[1];
        w_stall  = bus.id_valid && !bus.flush && (w_raw || w_waw || w_fwd || w_struct);
        w_issue  = bus.id_valid && bus.id_is_mult && !w_stall && !bus.flush;
        w_retire = r_pipe_valid[MULT_LAT-1] && r_pipe_wr[MULT_LAT-1];
    end

    // Clear applied before set so a same-edge reissue of the register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_retire) begin
            w_busy_nxt[r_pipe_dst[MULT_LAT-1]] = 1'b0;
        end
        if (w_issue && bus.id_regwrite && (bus.id_dst_reg != '0)) begin
            w_busy_nxt[bus.id_dst_reg] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < MULT_LAT; k++) begin
            w_inflight = w_inflight + 3'(r_pipe_valid[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_valid <= '0;
            r_pipe_wr    <= '0;
            r_pipe_dst   <= '0;
            r_busy       <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_dst     <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_pipe_valid <= {r_pipe_valid[MULT_LAT-2:0], w_issue};
            r_pipe_wr    <= {r_pipe_wr[MULT_LAT-2:0], bus.id_regwrite};
            for (int k = MULT_LAT - 1; k > 0; k--) begin
                r_pipe_dst[k] <= r_pipe_dst[k-1];
            end
            r_pipe_dst[0] <= bus.id_dst_reg;
            r_busy        <= w_busy_nxt;
            r_wb_valid    <= r_pipe_valid[MULT_LAT-1];
            r_wb_dst      <= r_pipe_dst[MULT_LAT-1];
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.stall         = w_stall;
    assign bus.mult_issue    = w_issue;
    assign bus.m_wb_valid    = r_wb_valid;
    assign bus.m_wb_dst      = r_wb_dst;
    assign bus.mult_inflight = w_inflight;
    assign bus.stall_cnt     = r_stall_cnt;
endmodule

`default_nettype wire

// File: tb/tb_mult_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mult_scheduler
// Description : Vector table plus scoreboarded write-back checks for mult_scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mult_scheduler;
    localparam int c_lat = 5;
    localparam int c_ra  = 5;

    typedef struct {
        string      name;
        logic       valid;
        logic       is_mult;
        logic       regwrite;
        logic [4:0] dst;
        logic [4:0] src1;
        logic [4:0] src2;
        logic [4:0] exd;
        logic       exw;
        logic [4:0] memd;
        logic       memw;
        logic       flush;
        logic       exp_stall;
        logic       exp_issue;
    } vec_t;

    typedef struct {
        logic [4:0] dst;
        int         due;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_stalls = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_scheduler_if #(.REG_ADDR(c_ra)) bus ();

    mult_scheduler #(.MULT_LAT(c_lat), .REG_ADDR(c_ra)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid        = v.valid;
        bus.id_is_mult      = v.is_mult;
        bus.id_regwrite     = v.regwrite;
        bus.id_dst_reg      = v.dst;
        bus.id_src1         = v.src1;
        bus.id_src2         = v.src2;
        bus.id_ex_dst_reg   = v.exd;
        bus.id_ex_regwrite  = v.exw;
        bus.ex_mem_dst_reg  = v.memd;
        bus.ex_mem_regwrite = v.memw;
        bus.flush           = v.flush;
    endtask

    function automatic vec_t mk(input string name, input logic valid, input logic is_mult,
                                input logic rw, input logic [4:0] dst, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [4:0] exd, input logic exw,
                                input logic [4:0] memd, input logic memw, input logic flush,
                                input logic es, input logic ei);
        vec_t v;
        v.name = name; v.valid = valid; v.is_mult = is_mult; v.regwrite = rw;
        v.dst = dst; v.src1 = s1; v.src2 = s2; v.exd = exd; v.exw = exw;
        v.memd = memd; v.memw = memw; v.flush = flush; v.exp_stall = es; v.exp_issue = ei;
        return v;
    endfunction

    task automatic idle();
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Drive one ID cycle, compare the combinational decisions, record any issue.
    task automatic apply_vec(input vec_t v);
        drive(v);
        #1;
        check({v.name, "_stall"}, 32'(bus.stall), 32'(v.exp_stall));
        check({v.name, "_issue"}, 32'(bus.mult_issue), 32'(v.exp_issue));
        if (v.exp_stall) exp_stalls++;
        if (v.exp_issue) sb.push_back('{dst: v.dst, due: cyc + c_lat + 1});
        next_cycle();
    endtask

    // Hold an instruction in ID until it stops stalling, then let it go.
    task automatic hold(input vec_t v, input int exp_n);
        int n = 0;
        drive(v);
        #1;
        while (bus.stall && n < 20) begin
            n++;
            @(posedge clk);
            #2;
        end
        check({v.name, "_stall_cycles"}, 32'(n), 32'(exp_n));
        check({v.name, "_issue"}, 32'(bus.mult_issue), 32'(v.is_mult));
        exp_stalls += exp_n;
        if (v.is_mult) sb.push_back('{dst: v.dst, due: cyc + c_lat + 1});
        next_cycle();
        idle();
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) next_cycle();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("wb_valid", 32'(bus.m_wb_valid), 32'd1);
                check("wb_dst", 32'(bus.m_wb_dst), 32'(sb[0].dst));
                void'(sb.pop_front());
            end else begin
                check("wb_idle", 32'(bus.m_wb_valid), 32'd0);
            end
        end
    end

    initial begin
        //             name        v  m  rw dst s1 s2 exd exw memd memw fl  st is
        tbl.push_back(mk("mul_free",   1, 1, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("mul_mem9",   1, 1, 1, 5, 9, 2, 0, 0, 9, 1, 0, 1, 0));
        tbl.push_back(mk("mul_src0",   1, 1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("mul_src0b",  1, 1, 1, 6, 0, 2, 0, 0, 9, 1, 0, 0, 1));
        tbl.push_back(mk("mul_ex6",    1, 1, 1, 8, 1, 6, 6, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("mul_ex6_nw", 1, 1, 1, 8, 1, 6, 6, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("alu_mem9",   1, 0, 1, 7, 9, 2, 0, 0, 9, 1, 0, 0, 0));
        tbl.push_back(mk("mul_flush",  1, 1, 1, 8, 9, 2, 0, 0, 9, 1, 1, 0, 0));
        tbl.push_back(mk("mul_inval",  0, 1, 1, 8, 1, 2, 0, 0, 0, 0, 0, 0, 0));

        idle();
        #3;
        check("rst_wb_valid", 32'(bus.m_wb_valid), 32'd0);
        check("rst_wb_dst", 32'(bus.m_wb_dst), 32'd0);
        check("rst_inflight", 32'(bus.mult_inflight), 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // First edge after release must be able to issue.
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_vec(mk("first_issue", 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drain(c_lat + 1);

        foreach (tbl[i]) begin
            apply_vec(tbl[i]);
            drain(c_lat + 1);
        end

        // Multiply r3 then a dependent ADD: five stall cycles.
        apply_vec(mk("mul_r3", 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        hold(mk("add_raw", 1, 0, 1, 8, 3, 0, 0, 0, 0, 0, 0, 0, 0), 5);
        drain(c_lat + 1);

        // ALU write two cycles after a multiply collides on the write port once.
        apply_vec(mk("mul_r4", 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply_vec(mk("gap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply_vec(mk("alu_wp", 1, 0, 1, 7, 1, 2, 0, 0, 0, 0, 0, 1, 0));
        apply_vec(mk("alu_wp_go", 1, 0, 1, 7, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        drain(c_lat + 1);

        // WAW on r4.
        apply_vec(mk("mul_r4b", 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        hold(mk("mul_waw", 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1), 5);
        drain(c_lat + 2);

        // Back-to-back multiplies fill the pipe.
        for (int i = 0; i < 5; i++) begin
            idle();
            #1;
            check("b2b_inflight", 32'(bus.mult_inflight), 32'(i));
            apply_vec(mk("b2b", 1, 1, 1, 5'(10 + i), 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        idle();
        #1;
        check("full_inflight", 32'(bus.mult_inflight), 32'd5);
        drain(c_lat + 2);
        check("stall_cnt", 32'(bus.stall_cnt), 32'(exp_stalls));

        // Asynchronous reset with three multiplies in flight.
        for (int i = 0; i < 3; i++) begin
            apply_vec(mk("pre_rst", 1, 1, 1, 5'(20 + i), 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        idle();
        #1;
        check("pre_rst_inflight", 32'(bus.mult_inflight), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check("arst_wb_valid", 32'(bus.m_wb_valid), 32'd0);
        check("arst_wb_dst", 32'(bus.m_wb_dst), 32'd0);
        check("arst_inflight", 32'(bus.mult_inflight), 32'd0);
        check("arst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        sb.delete();
        next_cycle();
        reset = 1'b1;
        apply_vec(mk("post_rst_issue", 1, 1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drain(c_lat + 4);

        for (int n = 0; n < 50 && sb.size() > 0; n++) next_cycle();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
